// File: rtl/mmio_host_requester.sv
// Host-side MMIO initiator: turns a local command stream into MMIO write/read
// request pulses, matches read responses by TID and reports data, timeout or error.
module mmio_host_requester #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 64,
  parameter int TID_W          = 9,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              mmio_wr_valid,
  output logic              mmio_rd_valid,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [TID_W-1:0]  mmio_tid,
  output logic [DATA_W-1:0] mmio_wdata,
  input  logic              rsp_in_valid,
  input  logic [TID_W-1:0]  rsp_in_tid,
  input  logic [DATA_W-1:0] rsp_in_data,
  output logic              wr_done,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_timeout,
  output logic              cmd_err,
  output logic [7:0]        stale_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_WR = 3'd1,
    ISSUE_RD = 3'd2,
    WAIT_RD  = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic              r_cmd_ready;
  logic              r_wr_valid, r_rd_valid, r_wr_done, r_rd_done;
  logic              r_rd_timeout, r_cmd_err;
  logic [ADDR_W-1:0] r_addr;
  logic [TID_W-1:0]  r_mmio_tid, r_tid, r_exp_tid;
  logic [DATA_W-1:0] r_wdata, r_rd_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_stale;

  logic w_accept, w_match, w_timeout, w_stale;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_match   = (r_state == WAIT_RD) && rsp_in_valid && (rsp_in_tid == r_exp_tid);
  // A matching response in the final wait cycle takes priority over the timeout.
  assign w_timeout = (r_state == WAIT_RD) && !w_match && (r_cnt == TO_LAST);
  assign w_stale   = rsp_in_valid && !w_match;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_addr[0])       w_next = ERR;
          else if (cmd_is_write) w_next = ISSUE_WR;
          else                   w_next = ISSUE_RD;
        end
      end
      ISSUE_WR: w_next = IDLE;
      ISSUE_RD: w_next = WAIT_RD;
      WAIT_RD:  if (w_match || w_timeout) w_next = IDLE;
      ERR:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Request outputs are loaded on the accepting edge so the pulse lines up
  // with the cycle spent in ISSUE_*; the TID advances as that state is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_wr_done    <= 1'b0;
      r_rd_done    <= 1'b0;
      r_rd_timeout <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_addr       <= '0;
      r_mmio_tid   <= '0;
      r_tid        <= '0;
      r_exp_tid    <= '0;
      r_wdata      <= '0;
      r_rd_data    <= '0;
      r_cnt        <= '0;
      r_stale      <= '0;
    end else begin
      r_state      <= w_next;
      r_cmd_ready  <= (w_next == IDLE);
      r_wr_valid   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_wr_done    <= 1'b0;
      r_rd_done    <= 1'b0;
      r_rd_timeout <= 1'b0;
      r_cmd_err    <= 1'b0;

      if (w_accept) begin
        if (cmd_addr[0]) begin
          r_cmd_err <= 1'b1;
        end else begin
          r_addr     <= cmd_addr;
          r_mmio_tid <= r_tid;
          if (cmd_is_write) begin
            r_wr_valid <= 1'b1;
            r_wr_done  <= 1'b1;
            r_wdata    <= cmd_wdata;
          end else begin
            r_rd_valid <= 1'b1;
            r_exp_tid  <= r_tid;
          end
        end
      end

      if (r_state == ISSUE_WR || r_state == ISSUE_RD)
        r_tid <= r_tid + 1'b1;

      if (r_state == ISSUE_RD)
        r_cnt <= '0;
      else if (r_state == WAIT_RD)
        r_cnt <= r_cnt + 1'b1;

      if (w_match) begin
        r_rd_done    <= 1'b1;
        r_rd_data    <= rsp_in_data;
        r_rd_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_rd_done    <= 1'b1;
        r_rd_data    <= '0;
        r_rd_timeout <= 1'b1;
      end

      if (w_stale && (r_stale != 8'hFF))
        r_stale <= r_stale + 1'b1;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign mmio_wr_valid = r_wr_valid;
  assign mmio_rd_valid = r_rd_valid;
  assign mmio_addr     = r_addr;
  assign mmio_tid      = r_mmio_tid;
  assign mmio_wdata    = r_wdata;
  assign wr_done       = r_wr_done;
  assign rd_done       = r_rd_done;
  assign rd_data       = r_rd_data;
  assign rd_timeout    = r_rd_timeout;
  assign cmd_err       = r_cmd_err;
  assign stale_cnt     = r_stale;

endmodule
